// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: fetch/decode/execute/memory/writeback sequencer
// with an embedded ALU decoder, a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int ALUCTL_W = 4,
    parameter int EXT_OPS  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic [2:0]          f3,
    input  logic [6:0]          f7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic                reg_write,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam bit EXT = (EXT_OPS != 0);

    state_t     state;
    state_t     decode_next;
    logic [3:0] funct_code;
    logic [3:0] alu_code;
    logic       funct_legal;
    logic       branch_legal;
    logic       f7_unused;

    assign f7_unused = ^{f7[6], f7[4:0]};

    // Extended functs decode to their codes in every build but are only reachable when EXT is set.
    always_comb begin
        funct_code  = ALU_ADD;
        funct_legal = 1'b1;
        case (f3)
            3'b000: funct_code = (op[5] & f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: begin funct_code = ALU_SLL;  funct_legal = EXT; end
            3'b010: funct_code = ALU_SLT;
            3'b011: begin funct_code = ALU_SLTU; funct_legal = EXT; end
            3'b100: begin funct_code = ALU_XOR;  funct_legal = EXT; end
            3'b101: begin funct_code = f7[5] ? ALU_SRA : ALU_SRL; funct_legal = EXT; end
            3'b110: funct_code = ALU_OR;
            default: funct_code = ALU_AND;
        endcase
    end

    assign branch_legal = (f3 == 3'b000) || (EXT && (f3 == 3'b001));

    always_comb begin
        decode_next = S_ILLEGAL;
        case (op)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_R:              decode_next = funct_legal ? S_EXEC_R : S_ILLEGAL;
            OP_I:              decode_next = funct_legal ? S_EXEC_I : S_ILLEGAL;
            OP_BRANCH:         decode_next = branch_legal ? S_BRANCH : S_ILLEGAL;
            OP_JAL:            decode_next = S_JAL;
            default:           decode_next = S_ILLEGAL;
        endcase
    end

    // mem_ready handshake: FETCH, MEMREAD and MEMWRITE keep presenting their access
    // until mem_ready is high at a rising edge; the access completes in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    state <= decode_next;
                    if (decode_next == S_ILLEGAL) illegal <= 1'b1;
                end
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_MEMWRITE: if (mem_ready) begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_EXEC_R, S_EXEC_I: state <= S_ALUWB;
                S_ALUWB, S_BRANCH: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_JAL:      state <= S_ALUWB;
                S_ILLEGAL: begin
                    state   <= S_ILLEGAL;
                    illegal <= 1'b1;
                end
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_code   = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            S_EXEC_R:   begin alu_src_a = 2'b10; alu_code = funct_code; end
            S_EXEC_I:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_code = funct_code; end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_code  = ALU_SUB;
                pc_write  = EXT ? (zero ^ f3[0]) : zero;
            end
            S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
            default: ;
        endcase
    end

    assign alu_control = ALUCTL_W'(alu_code);

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an extended build and a legacy build
// (EXT_OPS=0, ALUCTL_W=3, CNT_W=2) driven from the same stimulus.
module tb_multicycle_ctrl;
    localparam int OW = 34;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8, A_SLTU = 4'd9;
    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

    logic clk, rst_n, zero, mem_ready;
    logic [6:0] op, f7;
    logic [2:0] f3;

    logic pc_write_m, adr_src_m, mem_write_m, ir_write_m, reg_write_m, illegal_m;
    logic [1:0] result_src_m, alu_src_a_m, alu_src_b_m, imm_src_m;
    logic [3:0] alu_control_m;
    logic [15:0] retired_m;
    logic pc_write_l, adr_src_l, mem_write_l, ir_write_l, reg_write_l, illegal_l;
    logic [1:0] result_src_l, alu_src_a_l, alu_src_b_l, imm_src_l;
    logic [2:0] alu_control_l;
    logic [1:0] retired_l;

    multicycle_ctrl #(.ALUCTL_W(4), .EXT_OPS(1), .CNT_W(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_m), .adr_src(adr_src_m), .mem_write(mem_write_m), .ir_write(ir_write_m),
        .result_src(result_src_m), .alu_src_a(alu_src_a_m), .alu_src_b(alu_src_b_m),
        .imm_src(imm_src_m), .reg_write(reg_write_m), .alu_control(alu_control_m),
        .illegal(illegal_m), .retired(retired_m)
    );

    multicycle_ctrl #(.ALUCTL_W(3), .EXT_OPS(0), .CNT_W(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_l), .adr_src(adr_src_l), .mem_write(mem_write_l), .ir_write(ir_write_l),
        .result_src(result_src_l), .alu_src_a(alu_src_a_l), .alu_src_b(alu_src_b_l),
        .imm_src(imm_src_l), .reg_write(reg_write_l), .alu_control(alu_control_l),
        .illegal(illegal_l), .retired(retired_l)
    );

    logic [OW-1:0] act_m, act_l;
    assign act_m = {pc_write_m, adr_src_m, mem_write_m, ir_write_m, result_src_m, alu_src_a_m,
                    alu_src_b_m, imm_src_m, reg_write_m, alu_control_m, illegal_m, retired_m};
    assign act_l = {pc_write_l, adr_src_l, mem_write_l, ir_write_l, result_src_l, alu_src_a_l,
                    alu_src_b_l, imm_src_l, reg_write_l, 1'b0, alu_control_l, illegal_l,
                    14'd0, retired_l};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          sel = 1'b0;
    int            cfg_ext = 1, cfg_aluw = 4, cfg_cntw = 16;
    logic [6:0]    cur_op = 7'd0;
    logic          ref_ill = 1'b0;
    int            ref_ret = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            OP_STORE: return 2'b01;
            OP_BR:    return 2'b10;
            OP_JAL:   return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7);
        case (a3)
            3'd0: return (o == OP_R && a7[5]) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return a7[5] ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic int classify(input logic [6:0] o, input logic [2:0] a3);
        case (o)
            OP_LOAD:  return C_LOAD;
            OP_STORE: return C_STORE;
            OP_R, OP_I: begin
                if (cfg_ext == 0 && (a3 == 3'd1 || a3 == 3'd3 || a3 == 3'd4 || a3 == 3'd5))
                    return C_ILL;
                return (o == OP_R) ? C_R : C_I;
            end
            OP_BR:    return (a3 == 3'd0 || (cfg_ext != 0 && a3 == 3'd1)) ? C_BR : C_ILL;
            OP_JAL:   return C_JAL;
            default:  return C_ILL;
        endcase
    endfunction

    function automatic logic [OW-1:0] ev(input logic pcw, input logic adr, input logic mw,
                                         input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                         input logic [1:0] sb, input logic regw, input logic [3:0] alu);
        logic [3:0] m;
        m = 4'((1 << cfg_aluw) - 1);
        return {pcw, adr, mw, irw, rs, sa, sb, imm_of(cur_op), regw, alu & m, ref_ill, 16'(ref_ret)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                        input logic mr, input logic z, input logic [OW-1:0] e, input string nm);
        @(posedge clk);
        #1;
        op = o; f3 = a3; f7 = a7; mem_ready = mr; zero = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        logic mr;
        @(posedge clk);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        mr = rb();
        op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        mem_ready = mr; zero = rb();
        cur_op = op; ref_ill = 1'b0; ref_ret = 0;
        exp_q.push_back(ev(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 1'b0, A_ADD));
        name_q.push_back("reset");
        step(op, f3, f7, 1'b0, rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, A_ADD), "reset_release");
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                             input int fst, input int mst, input int zf);
        int   cls;
        logic z, mr;
        cur_op = o;
        cls = classify(o, a3);
        for (int i = 0; i < fst; i++)
            step(o, a3, a7, 1'b0, rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, A_ADD), "fetch_stall");
        step(o, a3, a7, 1'b1, rb(), ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, A_ADD), "fetch");
        step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, A_ADD), "decode");
        case (cls)
            C_LOAD, C_STORE: begin
                step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, A_ADD), "memadr");
                for (int i = 0; i <= mst; i++) begin
                    mr = (i == mst);
                    if (cls == C_LOAD)
                        step(o, a3, a7, mr, rb(), ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, A_ADD), "memread");
                    else
                        step(o, a3, a7, mr, rb(), ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, A_ADD), "memwrite");
                end
                if (cls == C_LOAD)
                    step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, A_ADD), "memwb");
            end
            C_R, C_I: begin
                step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, (cls == C_I) ? 2'b01 : 2'b00,
                                               1'b0, alu_of(o, a3, a7)), "exec");
                step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, A_ADD), "aluwb");
            end
            C_BR: begin
                z = (zf < 0) ? rb() : zf[0];
                step(o, a3, a7, rb(), z, ev(z ^ ((cfg_ext != 0) & a3[0]), 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                                             1'b0, A_SUB), "branch");
            end
            C_JAL: begin
                step(o, a3, a7, rb(), rb(), ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, A_ADD), "jal");
                step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, A_ADD), "aluwb");
            end
            default: begin
                ref_ill = 1'b1;
                for (int i = 0; i < 10; i++)
                    step(o, a3, a7, rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, A_ADD), "illegal");
                do_reset();
            end
        endcase
        if (cls != C_ILL) ref_ret = (ref_ret + 1) % (1 << cfg_cntw);
    endtask

    task automatic run_random(input int n);
        logic [6:0] o, a7;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: o = OP_LOAD;
                1: o = OP_STORE;
                2, 7: o = OP_R;
                3: o = OP_I;
                4: o = OP_BR;
                5: o = OP_JAL;
                default: o = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: a7 = 7'h00;
                1: a7 = 7'h20;
                default: a7 = 7'($urandom);
            endcase
            run_instr(o, 3'($urandom), a7, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [OW-1:0] mon_exp, mon_act;
    string         mon_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = sel ? act_l : act_m;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s (%s build): got %h expected %h", mon_name, sel ? "legacy" : "ext", mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();
        run_instr(OP_R, 3'd0, 7'h20, 3, 0, -1);
        run_instr(OP_R, 3'd0, 7'h00, 0, 0, -1);
        run_instr(OP_LOAD, 3'd2, 7'h00, 0, 2, -1);
        run_instr(OP_STORE, 3'd2, 7'h00, 1, 1, -1);
        run_instr(OP_BR, 3'd0, 7'h00, 0, 0, 1);
        run_instr(OP_BR, 3'd0, 7'h00, 0, 0, 0);
        run_instr(OP_BR, 3'd1, 7'h00, 0, 0, 1);
        run_instr(OP_BR, 3'd1, 7'h00, 0, 0, 0);
        run_instr(OP_I, 3'd5, 7'h20, 0, 0, -1);
        run_instr(OP_I, 3'd0, 7'h20, 0, 0, -1);
        run_instr(OP_R, 3'd5, 7'h00, 0, 0, -1);
        run_instr(OP_JAL, 3'd0, 7'h00, 0, 0, -1);
        run_instr(7'h7f, 3'd0, 7'h00, 0, 0, -1);
        run_instr(OP_BR, 3'd2, 7'h00, 0, 0, -1);
        run_random(200);

        @(negedge clk);
        #1;
        sel = 1'b1; cfg_ext = 0; cfg_aluw = 3; cfg_cntw = 2;
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(OP_I, 3'd0, 7'h00, 0, 0, -1);
        run_instr(OP_R, 3'd0, 7'h20, 1, 0, -1);
        run_instr(OP_BR, 3'd1, 7'h00, 0, 0, 1);
        run_instr(OP_R, 3'd1, 7'h00, 0, 0, -1);
        run_instr(OP_BR, 3'd0, 7'h00, 0, 0, 1);
        run_random(100);
        cur_op = OP_I;
        step(OP_I, 3'd0, 7'h00, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, A_ADD), "final_stall");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
